// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag types for the sequential ALU.
// Build option: ALU_MUL_EN enables the iterative multiplier in alu_seq.
package alu_pkg;

    typedef enum logic [3:0] {
        CMD_ADD   = 4'd0,
        CMD_SUB   = 4'd1,
        CMD_XOR   = 4'd2,
        CMD_SLT   = 4'd3,
        CMD_AND   = 4'd4,
        CMD_NAND  = 4'd5,
        CMD_NOR   = 4'd6,
        CMD_OR    = 4'd7,
        CMD_MUL   = 4'd8,
        CMD_SLL   = 4'd9,
        CMD_SRL   = 4'd10,
        CMD_SRA   = 4'd11,
        CMD_ILL12 = 4'd12,
        CMD_ILL13 = 4'd13,
        CMD_ILL14 = 4'd14,
        CMD_ILL15 = 4'd15
    } alu_cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
        logic illegal;
    } alu_flags_t;

    function automatic logic is_addsub(input alu_cmd_e cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB);
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: arithmetic, logic, compare, shifts and illegal decode.
// MUL is not handled here and decodes as illegal; alu_seq overrides it when enabled.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_cmd_e         cmd,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned AW = WIDTH + 1;

    logic [WIDTH-1:0] b_op;
    logic [AW-1:0]    sum;
    logic [SW-1:0]    shamt;

    always_comb begin
        b_op   = (cmd == CMD_SUB) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_op} + AW'(cmd == CMD_SUB);
        shamt  = b[SW-1:0];
        result = '0;
        flags  = '0;
        case (cmd)
            CMD_ADD, CMD_SUB: begin
                result         = sum[WIDTH-1:0];
                flags.carry    = sum[WIDTH];
                // Operands of equal sign producing a result of the other sign
                flags.overflow = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            CMD_XOR:  result = a ^ b;
            CMD_SLT:  result = WIDTH'($signed(a) < $signed(b));
            CMD_AND:  result = a & b;
            CMD_NAND: result = ~(a & b);
            CMD_NOR:  result = ~(a | b);
            CMD_OR:   result = a | b;
            CMD_SLL:  result = a << shamt;
            CMD_SRL:  result = a >> shamt;
            CMD_SRA:  result = WIDTH'($signed(a) >>> shamt);
            default:  flags.illegal = 1'b1;
        endcase
        flags.zero = is_addsub(cmd) && (result == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered results held until accepted downstream.
// Build option: ALU_MUL_EN adds a WIDTH-cycle shift-add multiplier (opcode 8); otherwise opcode 8 is illegal.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [3:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    logic             live_q, live_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic [WIDTH-1:0] comb_result;
    alu_flags_t       comb_flags;
    alu_cmd_e         cmd;
    logic             accept;
    logic             idle;

    assign cmd = alu_cmd_e'(command);

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a      (operandA),
        .b      (operandB),
        .cmd    (cmd),
        .result (comb_result),
        .flags  (comb_flags)
    );

`ifdef ALU_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign idle = (state_q == IDLE);
`else
    assign idle = 1'b1;
`endif

    // live_q holds in_ready low for the first cycle after reset release
    assign in_ready = live_q && idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        live_d      = 1'b1;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;
`ifdef ALU_MUL_EN
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd == CMD_MUL) begin
                        mcand_d  = operandA;
                        mplier_d = operandB;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d    = comb_result;
                        flags_d     = comb_flags;
                        out_valid_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Last iteration: publish the updated accumulator directly
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d    = acc_d;
                    flags_d     = '0;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`else
        if (accept) begin
            result_d    = comb_result;
            flags_d     = comb_flags;
            out_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            live_q      <= live_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryout  = flags_q.carry;
    assign zero      = flags_q.zero;
    assign overflow  = flags_q.overflow;
    assign illegal   = flags_q.illegal;

endmodule
